ascon_serial_loader: RTL

Host-side transmitter for the Ascon core's bit-serial input interface. Accepts key, nonce, associated data and plaintext as parallel words through a valid/ready handshake. Shifts them into the core MSB-first, one bit per lane per cycle, and drives the randomness/share bits on every shift cycle. It then asserts the encryption or decryption start strobe. It sits between the host bus and the core's serial ports, replacing the hand-driven write sequence.

---
 rtl/ascon_loader_pkg.sv | 37 +++
 rtl/ascon_lfsr.sv | 35 +++
 rtl/ascon_serial_loader.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/ascon_loader_pkg.sv
// Shared types and constants for the Ascon serial loader: FSM states,
// packed random-word layout and LFSR geometry.
package ascon_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        START
    } loaderState_t;

    localparam int unsigned NONCE_W  = 128;

    // Packed random word, MSB to LSB: {r_128, r_pt, r_64, key, ad, pt, nonce}
    localparam int unsigned RND_W    = 36;
    localparam int unsigned LANE_RW  = 4;
    localparam int unsigned NONCE_OFF = 0;
    localparam int unsigned PT_OFF   = 4;
    localparam int unsigned AD_OFF   = 8;
    localparam int unsigned KEY_OFF  = 12;
    localparam int unsigned R64_OFF  = 16;
    localparam int unsigned R64_W    = 14;
    localparam int unsigned RPT_OFF  = 30;
    localparam int unsigned RPT_W    = 3;
    localparam int unsigned R128_OFF = 33;
    localparam int unsigned R128_W   = 3;

    // Fibonacci LFSR x^41 + x^38 + 1
    localparam int unsigned LFSR_W      = 41;
    localparam int unsigned LFSR_TAP_HI = 40;
    localparam int unsigned LFSR_TAP_LO = 37;
    localparam int unsigned LFSR_STEPS  = 36;

    function automatic logic [LFSR_W-1:0] lfsrStep(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/ascon_lfsr.sv
// 41-bit Fibonacci LFSR advancing LFSR_STEPS steps per enabled cycle;
// used by the loader only when ASCON_LOADER_LFSR_EN is defined.
module ascon_lfsr
    import ascon_loader_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 41'h0_1234_5678_9A
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [RND_W-1:0] rnd
);

    logic [LFSR_W-1:0] lfsrQ;
    logic [LFSR_W-1:0] lfsrD;

    always_comb begin
        lfsrD = lfsrQ;
        for (int unsigned i = 0; i < LFSR_STEPS; i++) begin
            lfsrD = lfsrStep(lfsrD);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsrQ <= SEED;
        end else if (en) begin
            lfsrQ <= lfsrD;
        end
    end

    // Word seen by the loader is the state it is about to advance to
    assign rnd = lfsrD[RND_W-1:0];

endmodule

// File: rtl/ascon_serial_loader.sv
// Parallel-to-serial loader for the Ascon core's bit-serial inputs.
// Optional internal randomness source: define ASCON_LOADER_LFSR_EN.
module ascon_serial_loader
    import ascon_loader_pkg::*;
#(
    parameter int                K            = 128,
    parameter int                Y            = 96,
    parameter int                L            = 40,
    parameter int                START_CYCLES = 5,
    parameter logic [LFSR_W-1:0] LFSR_SEED    = 41'h0_1234_5678_9A
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic               mode_i,
    input  logic [K-1:0]       key_i,
    input  logic [NONCE_W-1:0] nonce_i,
    input  logic [L-1:0]       ad_i,
    input  logic [Y-1:0]       pt_i,
    input  logic [RND_W-1:0]   rnd_i,
    output logic [4:0]         keyxSO,
    output logic [4:0]         noncexSO,
    output logic [4:0]         associated_dataxSO,
    output logic [4:0]         plain_textxSO,
    output logic [13:0]        r_64xSO,
    output logic [2:0]         r_128xSO,
    output logic [2:0]         r_ptxSO,
    output logic               encryption_startxSO,
    output logic               decryption_startxSO,
    output logic               done
);

    localparam int MAX   = (K > Y) ? ((K > L) ? K : L) : ((Y > L) ? Y : L);
    localparam int CNT_W = $clog2(MAX + 1);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(MAX - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYCLES - 1);

    loaderState_t     state, stateNxt;
    logic [CNT_W-1:0] cnt, cntNxt;
    logic             accept;

    logic [K-1:0]       keySh;
    logic [NONCE_W-1:0] nonceSh;
    logic [L-1:0]       adSh;
    logic [Y-1:0]       ptSh;
    logic               modeR;

    logic             keyBit, nonceBit, adBit, ptBit;
    logic [RND_W-1:0] rndWord;
    logic [RND_W-1:0] rndSrc;

`ifdef ASCON_LOADER_LFSR_EN
    logic [RND_W-1:0] unusedRnd;
    assign unusedRnd = rnd_i;

    ascon_lfsr #(
        .SEED(LFSR_SEED)
    ) uLfsr (
        .clk(clk),
        .rst(rst),
        .en (state == SHIFT),
        .rnd(rndSrc)
    );
`else
    logic unusedSeed;
    assign unusedSeed = ^LFSR_SEED;
    assign rndSrc     = rnd_i;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNxt;
            cnt   <= cntNxt;
        end
    end

    always_comb begin
        stateNxt = state;
        cntNxt   = cnt;
        accept   = 1'b0;
        unique case (state)
            IDLE: begin
                if (load_valid && load_ready) begin
                    accept   = 1'b1;
                    stateNxt = SHIFT;
                    cntNxt   = '0;
                end
            end
            SHIFT: begin
                if (cnt == SHIFT_LAST) begin
                    stateNxt = START;
                    cntNxt   = '0;
                end else begin
                    cntNxt = cnt + CNT_W'(1);
                end
            end
            START: begin
                if (cnt == START_LAST) begin
                    stateNxt = IDLE;
                    cntNxt   = '0;
                end else begin
                    cntNxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                stateNxt = IDLE;
                cntNxt   = '0;
            end
        endcase
    end

    // Each lane shifts left with zero fill, so exhausted lanes emit 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            keySh   <= '0;
            nonceSh <= '0;
            adSh    <= '0;
            ptSh    <= '0;
            modeR   <= 1'b0;
        end else if (accept) begin
            keySh   <= key_i;
            nonceSh <= nonce_i;
            adSh    <= ad_i;
            ptSh    <= pt_i;
            modeR   <= mode_i;
        end else if (state == SHIFT) begin
            keySh   <= {keySh[K-2:0], 1'b0};
            nonceSh <= {nonceSh[NONCE_W-2:0], 1'b0};
            adSh    <= {adSh[L-2:0], 1'b0};
            ptSh    <= {ptSh[Y-2:0], 1'b0};
        end
    end

    // load_ready follows the next state so a new job can be taken on the
    // first IDLE edge; everything else reflects the current state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_ready          <= 1'b0;
            keyBit              <= 1'b0;
            nonceBit            <= 1'b0;
            adBit               <= 1'b0;
            ptBit               <= 1'b0;
            rndWord             <= '0;
            encryption_startxSO <= 1'b0;
            decryption_startxSO <= 1'b0;
            done                <= 1'b0;
        end else begin
            load_ready          <= (stateNxt == IDLE);
            keyBit              <= (state == SHIFT) && keySh[K-1];
            nonceBit            <= (state == SHIFT) && nonceSh[NONCE_W-1];
            adBit               <= (state == SHIFT) && adSh[L-1];
            ptBit               <= (state == SHIFT) && ptSh[Y-1];
            rndWord             <= (state == SHIFT) ? rndSrc : '0;
            encryption_startxSO <= (state == START) && !modeR;
            decryption_startxSO <= (state == START) && modeR;
            done                <= (state == START) && (cnt == START_LAST);
        end
    end

    assign keyxSO             = {rndWord[KEY_OFF   +: LANE_RW], keyBit};
    assign noncexSO           = {rndWord[NONCE_OFF +: LANE_RW], nonceBit};
    assign associated_dataxSO = {rndWord[AD_OFF    +: LANE_RW], adBit};
    assign plain_textxSO      = {rndWord[PT_OFF    +: LANE_RW], ptBit};
    assign r_64xSO            = rndWord[R64_OFF  +: R64_W];
    assign r_ptxSO            = rndWord[RPT_OFF  +: RPT_W];
    assign r_128xSO           = rndWord[R128_OFF +: R128_W];

endmodule
